// File: rtl/mem_arb_pkg.sv
// Purpose: shared types for the fetch/data memory-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: FSM state type, requester ID type, byte-enable all-ones constant.
package mem_arb_pkg;

  // Arbiter FSM states. The S_ prefix keeps them distinct from the requester IDs.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_REQ_I  = 3'd1,
    S_WAIT_I = 3'd2,
    S_REQ_D  = 3'd3,
    S_WAIT_D = 3'd4
  } arbState_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } reqId_t;

  // Wide enough for any data width up to 512 bits; users slice the low DATA_W/8 bits.
  localparam logic [63:0] BE_ALL_ONES = '1;

endpackage

// File: rtl/mem_arb_pick.sv
// Purpose: combinational winner select between fetch and data requests.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller masks requests that must not be selected.
// Ports: reqI/reqD masked requests, lastServed (ARB_FAIR_EN only), gntVld/gntId winner.
// Config: with ARB_FAIR_EN defined, priority alternates; otherwise data always wins.
import mem_arb_pkg::*;

module mem_arb_pick (
  input  logic   reqI,
  input  logic   reqD,
`ifdef ARB_FAIR_EN
  input  reqId_t lastServed,
`endif
  output logic   gntVld,
  output reqId_t gntId
);

  always_comb begin
    gntVld = reqI | reqD;
    gntId  = REQ_I;
`ifdef ARB_FAIR_EN
    if (reqI && reqD) begin
      // On contention, hand the port to whichever side did not go last.
      gntId = (lastServed == REQ_D) ? REQ_I : REQ_D;
    end else if (reqD) begin
      gntId = REQ_D;
    end
`else
    if (reqD) begin
      gntId = REQ_D;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one single-ported memory between fetch and load/store requesters.
// Latency: request seen in IDLE -> Valid pulse 3 cycles later at best (gnt at once, rvalid +1).
// Backpressure: one transaction at a time; requesters stall (StallF/StallM) until their Valid pulse.
// Ports: fetch (IReqF/IAddrF/IRdataF/IValidF/StallF), data (DReqM/DWeM/DAddrM/DWdataM/DBeM/
//        DRdataM/DValidM/StallM), memory (mem_req/we/addr/wdata/be out, mem_gnt/rvalid/rdata in).
// Config: define ARB_FAIR_EN for alternating priority; default is strict data priority.
import mem_arb_pkg::*;

module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                IReqF,
  input  logic [ADDR_W-1:0]   IAddrF,
  output logic [DATA_W-1:0]   IRdataF,
  output logic                IValidF,
  output logic                StallF,
  input  logic                DReqM,
  input  logic                DWeM,
  input  logic [ADDR_W-1:0]   DAddrM,
  input  logic [DATA_W-1:0]   DWdataM,
  input  logic [DATA_W/8-1:0] DBeM,
  output logic [DATA_W-1:0]   DRdataM,
  output logic                DValidM,
  output logic                StallM,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int BE_W = DATA_W / 8;
  localparam logic [BE_W-1:0] BE_READ = BE_ALL_ONES[BE_W-1:0];

  arbState_t state;
  logic      qualI;
  logic      qualD;
  logic      pickVld;
  reqId_t    pickId;

  // A requester whose Valid is high this cycle was just served; its Req is
  // still asserted only because the pipeline has not advanced yet.
  assign qualI  = IReqF & ~IValidF;
  assign qualD  = DReqM & ~DValidM;

  assign StallF = IReqF & ~IValidF;
  assign StallM = DReqM & ~DValidM;

`ifdef ARB_FAIR_EN
  reqId_t lastServed;
`endif

  mem_arb_pick uPick (
    .reqI       (qualI),
    .reqD       (qualD),
`ifdef ARB_FAIR_EN
    .lastServed (lastServed),
`endif
    .gntVld     (pickVld),
    .gntId      (pickId)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      IRdataF   <= '0;
      DRdataM   <= '0;
      IValidF   <= 1'b0;
      DValidM   <= 1'b0;
`ifdef ARB_FAIR_EN
      lastServed <= REQ_I;
`endif
    end else begin
      IValidF <= 1'b0;
      DValidM <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pickVld) begin
            mem_req <= 1'b1;
`ifdef ARB_FAIR_EN
            lastServed <= pickId;
`endif
            if (pickId == REQ_D) begin
              mem_we    <= DWeM;
              mem_addr  <= DAddrM;
              mem_wdata <= DWdataM;
              mem_be    <= DWeM ? DBeM : BE_READ;
              state     <= S_REQ_D;
            end else begin
              mem_we    <= 1'b0;
              mem_addr  <= IAddrF;
              mem_wdata <= '0;
              mem_be    <= BE_READ;
              state     <= S_REQ_I;
            end
          end
        end
        S_REQ_I: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT_I;
          end
        end
        S_REQ_D: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            state   <= S_WAIT_D;
          end
        end
        S_WAIT_I: begin
          if (mem_rvalid) begin
            IRdataF <= mem_rdata;
            // A flushed fetch still drains the memory, but nobody is waiting for it.
            IValidF <= IReqF;
            state   <= S_IDLE;
          end
        end
        S_WAIT_D: begin
          if (mem_rvalid) begin
            if (!mem_we) begin
              DRdataM <= mem_rdata;
            end
            DValidM <= DReqM;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the fetch-stage instruction request and the memory-stage load/store request.
- Sequences one outstanding transaction at a time through a request/grant/response handshake.
- Returns read data to each requester.
- Drives per-stage stall outputs that the pipeline uses to freeze while its access is pending.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- IReqF  in  1  fetch read request; held until IValidF.
- IAddrF  in  ADDR_W  fetch address.
- IRdataF  out  DATA_W  fetched instruction, registered.
- IValidF  out  1  one-cycle pulse: IRdataF is valid.
- StallF  out  1  equals IReqF & ~IValidF.
- DReqM  in  1  data request; held until DValidM.
- DWeM  in  1  1 = store, 0 = load.
- DAddrM  in  ADDR_W  data address.
- DWdataM  in  DATA_W  store data.
- DBeM  in  DATA_W/8  store byte enables.
- DRdataM  out  DATA_W  load data, registered.
- DValidM  out  1  one-cycle pulse: load data valid or store done.
- StallM  out  1  equals DReqM & ~DValidM.
- mem_req  out  1  memory request, registered.
- mem_we  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  write data.
- mem_be  out  DATA_W/8  byte enables; all-ones for reads.
- mem_gnt  in  1  memory accepts request this cycle.
- mem_rvalid  in  1  response (read data or write ack); earliest one cycle after gnt.
- mem_rdata  in  DATA_W  read data.

Behaviour:
- States: IDLE, REQ_I, WAIT_I, REQ_D, WAIT_D.
- Reset: state = IDLE. All mem_* outputs, IRdataF, DRdataM, IValidF and DValidM are 0.
- IDLE, choosing the next requester:
  - DReqM has priority over IReqF.
  - The winner's address, write data, byte enables and we are captured into the mem_* registers.
  - mem_req is set to 1 and the FSM moves to REQ_D or REQ_I.
  - If neither requester qualifies, the FSM stays in IDLE.
- Masking: a requester whose Valid output is high in the current cycle is excluded from selection, so an already-served request is never reissued.
- REQ_x: mem_req and the captured mem_* outputs stay stable until mem_gnt = 1. In that cycle mem_req clears and the FSM moves to WAIT_x.
- WAIT_x: on mem_rvalid:
  - The matching Rdata register captures mem_rdata. For stores, the Rdata register is left unchanged.
  - Next cycle, the matching Valid output pulses for exactly one cycle.
  - The FSM returns to IDLE.
- Minimum latency, with gnt in the first REQ cycle and rvalid one cycle later:
  - cycle 0: request seen in IDLE.
  - cycle 1: mem_req = 1, mem_gnt = 1.
  - cycle 2: mem_rvalid = 1.
  - cycle 3: Valid pulse.
  - Stall is high during cycles 0-2 and low in cycle 3.
- Requester withdraws mid-transaction (e.g. IReqF dropped on branch flush): the transaction still completes on the memory side. The Valid pulse is suppressed if that requester's Req is low in the response-capture cycle.
- mem_rvalid in IDLE or REQ_x: ignored.
- mem_gnt outside REQ_x: ignored.
- Simultaneous IReqF and DReqM in IDLE: D is served first. I is served on the next IDLE decision, which is not masked for I.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs cleared. Any later rvalid from the abandoned access falls in IDLE and is ignored.

Optional Feature:
- Macro: ARB_FAIR_EN.
- Defined: alternating priority. A 1-bit last-served flip-flop (reset value: I) is kept.
  - When both requesters qualify in IDLE, the one not served last wins.
  - A single qualifying requester always wins.
- Undefined: strict data priority as described in Behaviour; no last-served register.

Decomposition:
- Package mem_arb_pkg holds:
  - FSM state typedef with a 3-bit encoding.
  - Requester-ID enum: REQ_I = 0, REQ_D = 1.
  - Byte-enable all-ones constant.
- One sub-module, mem_arb_pick: combinational winner select.
  - Inputs: masked requests, and last-served when ARB_FAIR_EN is defined.
  - Outputs: grant valid and requester ID.
- FSM, mem_* registers and response registers stay in mem_port_arbiter.

Test Plan:
- Single fetch: IReqF = 1, IAddrF = 0x0000_0010, gnt immediately, rvalid one cycle later with rdata = 0x0010_0093 -> mem_addr = 0x10, mem_we = 0, mem_be = 0xF; IRdataF = 0x0010_0093 and IValidF pulse in cycle 3; StallF high in cycles 0-2.
- Store: DReqM = 1, DWeM = 1, DAddrM = 0x100, DWdataM = 0xDEAD_BEEF, DBeM = 0x3, gnt delayed 2 cycles -> mem_req held 3 cycles with stable outputs; DValidM pulses once; DRdataM unchanged.
- Contention: IReqF and DReqM both asserted in the same cycle -> D issued first, I issued in the IDLE cycle after DValidM; no duplicate D request. With ARB_FAIR_EN and last-served = D, I is issued first.
- Back-to-back fetch: IReqF held high with a new IAddrF (0x14) in the IValidF cycle -> no reissue of 0x10; 0x14 issued on the next IDLE decision.
- Flush: IReqF dropped while in WAIT_I -> the transaction completes; IValidF stays 0; the FSM returns to IDLE.
- Reset in WAIT_D, with rvalid arriving 1 cycle after reset release -> all outputs 0; rvalid ignored; no DValidM.
